// File: rtl/his_builder_fsm.sv
// Per-pixel coarse timestamp histogrammer: accumulates ACQ_NUM sweeps, then scans for each pixel's peak bin.
// Optional build macro PEAK_VALID_EN adds a one-cycle peakValid pulse alongside each new peakResult.
//
// state | meaning
// ACCUM | accepting interleaved samples into the per-pixel histograms
// SCAN  | walking bins 0..NBINS-1 for all pixels, then publishing peaks and returning to ACCUM
module his_builder_fsm #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int ACQ_NUM           = 2,
    parameter int BIN_BITS          = 4,
    parameter int CNT_W             = $clog2(ACQ_NUM + 1)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
`ifdef PEAK_VALID_EN
    output logic          peakValid,
`endif
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM]
);

    localparam int NBINS = 2 ** BIN_BITS;
    localparam int PTR_W = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int SL_W  = BIN_BITS + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACCUM = 2'b00,
        SCAN  = 2'b01
    } state_t;

    state_t state, stateNext;

    logic [PTR_W-1:0]    pixPtr;
    logic [ACQ_W-1:0]    acqCnt;
    logic [SL_W-1:0]     scanLeft;
    logic [CNT_W-1:0]    hist    [PIXEL_NUM_PER_RAM][NBINS];
    logic [CNT_W-1:0]    best    [PIXEL_NUM_PER_RAM];
    logic [BIN_BITS-1:0] bestIdx [PIXEL_NUM_PER_RAM];

    logic                accept;
    logic                ptrWrap;
    logic                acqLast;
    logic                scanDone;
    logic [BIN_BITS-1:0] binIn;
    logic [BIN_BITS-1:0] scanBin;

    assign accept   = (state == ACCUM) && wrEn;
    assign ptrWrap  = (pixPtr == PTR_LAST);
    assign acqLast  = (acqCnt == ACQ_LAST);
    assign scanDone = (scanLeft == '0);
    assign binIn    = data[NP-1 -: BIN_BITS];
    // scanLeft counts down from NBINS; the bin index climbs so ties resolve to the lower bin
    assign scanBin  = BIN_BITS'(SL_W'(NBINS) - scanLeft);

    always_ff @(posedge clk) begin
        if (res) state <= ACCUM;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ACCUM:   if (accept && ptrWrap && acqLast) stateNext = SCAN;
            SCAN:    if (scanDone) stateNext = ACCUM;
            default: stateNext = ACCUM;
        endcase
    end

`ifdef PEAK_VALID_EN
    logic peakValidQ;
    assign peakValid = peakValidQ;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            pixPtr   <= '0;
            acqCnt   <= '0;
            scanLeft <= '0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                for (int b = 0; b < NBINS; b++) hist[p][b] <= '0;
                best[p]       <= '0;
                bestIdx[p]    <= '0;
                peakResult[p] <= '0;
            end
`ifdef PEAK_VALID_EN
            peakValidQ <= 1'b0;
`endif
        end else begin
`ifdef PEAK_VALID_EN
            peakValidQ <= 1'b0;
`endif
            if (state == ACCUM) begin
                scanLeft <= SL_W'(NBINS);
                if (accept) begin
                    // zero is the no-photon marker: the slot is consumed but nothing is counted
                    if ((data != '0) && (hist[pixPtr][binIn] != CNT_MAX))
                        hist[pixPtr][binIn] <= hist[pixPtr][binIn] + 1'b1;
                    if (ptrWrap) begin
                        pixPtr <= '0;
                        acqCnt <= acqLast ? '0 : acqCnt + 1'b1;
                    end else begin
                        pixPtr <= pixPtr + 1'b1;
                    end
                end
            end else if (state == SCAN) begin
                if (!scanDone) begin
                    scanLeft <= scanLeft - 1'b1;
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        if (hist[p][scanBin] > best[p]) begin
                            best[p]    <= hist[p][scanBin];
                            bestIdx[p] <= scanBin;
                        end
                        hist[p][scanBin] <= '0;
                    end
                end else begin
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        peakResult[p] <= {bestIdx[p], {(NP-BIN_BITS){1'b0}}};
                        best[p]       <= '0;
                        bestIdx[p]    <= '0;
                    end
`ifdef PEAK_VALID_EN
                    peakValidQ <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed bench for his_builder_fsm (NP=10, 3 pixels, 2 acquisitions, 16 bins of width 64).
// Build with PEAK_VALID_EN defined to also exercise the peakValid pulse.
module tb_his_builder_fsm;

    logic       clk = 1'b0;
    logic       res;
    logic       wrEn;
    logic [9:0] data;
    logic [9:0] peakResult [3];
`ifdef PEAK_VALID_EN
    logic       peakValid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    his_builder_fsm #(
        .NP(10), .PIXEL_NUM_PER_RAM(3), .ACQ_NUM(2), .BIN_BITS(4)
    ) dut (
        .clk(clk),
        .res(res),
        .wrEn(wrEn),
        .data(data),
`ifdef PEAK_VALID_EN
        .peakValid(peakValid),
`endif
        .peakResult(peakResult)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic streamFrame(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                               input logic [9:0] a3, input logic [9:0] a4, input logic [9:0] a5);
        logic [9:0] s [6];
        s = '{a0, a1, a2, a3, a4, a5};
        for (int i = 0; i < 6; i++) begin
            wrEn = 1'b1;
            data = s[i];
            step();
        end
        wrEn = 1'b0;
        data = '0;
    endtask

    task automatic test_reset();
        res = 1'b1; wrEn = 1'b0; data = '0;
        step(); step();
        res = 1'b0;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd0) begin
                errors++;
                $display("FAIL reset_peak pix%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        repeat (100) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd0) begin
                errors++;
                $display("FAIL idle_peak pix%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        checks++;
        if (dut.state !== 2'b00 || dut.pixPtr !== 2'd0) begin
            errors++;
            $display("FAIL idle_state: state %0d ptr %0d expected 0 0", dut.state, dut.pixPtr);
        end
`ifdef PEAK_VALID_EN
        checks++;
        if (peakValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %b expected 0", peakValid);
        end
`endif
    endtask

    task automatic test_basic_frame();
        logic [9:0] exp [3];
        int earlyValid;
        exp = '{10'd64, 10'd64, 10'd960};
        earlyValid = 0;
        streamFrame(108, 511, 1022, 108, 90, 1022);
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef PEAK_VALID_EN
            if (peakValid !== 1'b0) earlyValid++;
`endif
        end
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd0) begin
                errors++;
                $display("FAIL basic_early pix%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== exp[p]) begin
                errors++;
                $display("FAIL basic_peak pix%0d: got %0d expected %0d", p, peakResult[p], exp[p]);
            end
        end
`ifdef PEAK_VALID_EN
        checks++;
        if (earlyValid != 0 || peakValid !== 1'b1) begin
            errors++;
            $display("FAIL valid_pulse: early %0d now %b expected 0 1", earlyValid, peakValid);
        end
        step();
        checks++;
        if (peakValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %b expected 0", peakValid);
        end
`else
        step();
`endif
        checks++;
        if (peakResult[2] !== 10'd960) begin
            errors++;
            $display("FAIL basic_hold: got %0d expected 960", peakResult[2]);
        end
    endtask

    task automatic test_tie_frame();
        logic [9:0] exp [3];
        exp = '{10'd256, 10'd0, 10'd0};
        streamFrame(300, 50, 48, 500, 1000, 90);
        repeat (17) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== exp[p]) begin
                errors++;
                $display("FAIL tie_peak pix%0d: got %0d expected %0d", p, peakResult[p], exp[p]);
            end
        end
    endtask

    task automatic test_empty_then_clear();
        streamFrame(0, 0, 0, 0, 0, 0);
        repeat (17) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd0) begin
                errors++;
                $display("FAIL empty_peak pix%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        streamFrame(700, 700, 700, 700, 700, 700);
        repeat (17) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd640) begin
                errors++;
                $display("FAIL refill_peak pix%0d: got %0d expected 640", p, peakResult[p]);
            end
        end
    endtask

    task automatic test_scan_ignore_and_reset();
        logic [9:0] exp [3];
        exp = '{10'd192, 10'd384, 10'd576};
        streamFrame(200, 400, 600, 200, 400, 600);
        wrEn = 1'b1;
        data = 10'd1023;
        repeat (17) step();
        wrEn = 1'b0;
        data = '0;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== exp[p]) begin
                errors++;
                $display("FAIL scan_frame pix%0d: got %0d expected %0d", p, peakResult[p], exp[p]);
            end
        end
        streamFrame(700, 700, 700, 700, 700, 700);
        repeat (17) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd640) begin
                errors++;
                $display("FAIL scan_drop pix%0d: got %0d expected 640", p, peakResult[p]);
            end
        end
        streamFrame(1000, 1000, 1000, 1000, 1000, 1000);
        repeat (5) step();
        res = 1'b1;
        step();
        res = 1'b0;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd0) begin
                errors++;
                $display("FAIL midscan_reset pix%0d: got %0d expected 0", p, peakResult[p]);
            end
        end
        checks++;
        if (dut.pixPtr !== 2'd0 || dut.state !== 2'b00) begin
            errors++;
            $display("FAIL midscan_state: ptr %0d state %0d expected 0 0", dut.pixPtr, dut.state);
        end
        repeat (20) step();
        checks++;
        if (peakResult[0] !== 10'd0) begin
            errors++;
            $display("FAIL midscan_abort: got %0d expected 0", peakResult[0]);
        end
    endtask

    task automatic test_back_to_back();
        streamFrame(511, 511, 511, 511, 511, 511);
        repeat (17) step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd448) begin
                errors++;
                $display("FAIL b2b_first pix%0d: got %0d expected 448", p, peakResult[p]);
            end
        end
        streamFrame(1022, 1022, 1022, 1022, 1022, 1022);
        repeat (16) step();
        checks++;
        if (peakResult[1] !== 10'd448) begin
            errors++;
            $display("FAIL b2b_early: got %0d expected 448", peakResult[1]);
        end
        step();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (peakResult[p] !== 10'd960) begin
                errors++;
                $display("FAIL b2b_second pix%0d: got %0d expected 960", p, peakResult[p]);
            end
        end
    endtask

    initial begin
        res  = 1'b1;
        wrEn = 1'b0;
        data = '0;
        test_reset();
        test_basic_frame();
        test_tie_frame();
        test_empty_then_clear();
        test_scan_ignore_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
